// File: rtl/issue_sched_pkg.sv
// ---------------------------------------------------------------------------
// issue_sched_pkg
// Shared processor definitions used by the issue scheduler, the CDB mux and
// the issue queues.
//   unit_e          : 2-bit code naming the execution unit that owns a CDB slot
//   DEF_LAT_*       : default issue-to-CDB latencies for each execution unit
//   RESV_DEPTH      : number of future CDB slots tracked (slot 0 = this cycle)
//   RESV_IDX_W      : width of an index into the slot vector
// ---------------------------------------------------------------------------
package issue_sched_pkg;

    typedef enum logic [1:0] {
        UNIT_INT = 2'b00,
        UNIT_LS  = 2'b01,
        UNIT_MUL = 2'b10,
        UNIT_DIV = 2'b11
    } unit_e;

    localparam int DEF_LAT_INT = 1;
    localparam int DEF_LAT_LS  = 1;
    localparam int DEF_LAT_MUL = 4;
    localparam int DEF_LAT_DIV = 7;

    // Latencies must lie in 1..RESV_DEPTH-1 so that slot L is visible for
    // the conflict check and slot L-1 can be written in the same update.
    localparam int RESV_DEPTH = 8;
    localparam int RESV_IDX_W = 3;

endpackage

// File: rtl/issue_sched_cdb_slot_tracker.sv
// ---------------------------------------------------------------------------
// cdb_slot_tracker
// Shift register of future CDB reservations. Bit k of resv_o means the CDB is
// taken k cycles from now; the companion array records which unit owns it.
// Every cycle the vector shifts one slot toward slot 0, and a single new
// reservation may be inserted in the same update.
//   clk, reset      : clock, synchronous active-high reset
//   set_i           : insert a reservation this cycle
//   set_slot_i      : post-shift slot index to mark (latency - 1)
//   set_src_i       : unit owning the new reservation
//   resv_o          : current reservation vector
//   src0_o          : owner of slot 0 (the unit driving the CDB now)
// ---------------------------------------------------------------------------
module cdb_slot_tracker
    import issue_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_i,
    input  logic [RESV_IDX_W-1:0] set_slot_i,
    input  unit_e                 set_src_i,
    output logic [RESV_DEPTH-1:0] resv_o,
    output unit_e                 src0_o
);

    logic [RESV_DEPTH-1:0] resv_q, resv_d;
    unit_e                 src_q [RESV_DEPTH];
    unit_e                 src_d [RESV_DEPTH];

    // The inserted slot is always empty after the shift because the arbiter
    // only grants when slot L was free before shifting.
    always_comb begin
        resv_d = resv_q >> 1;
        for (int i = 0; i < RESV_DEPTH - 1; i++) begin
            src_d[i] = src_q[i+1];
        end
        src_d[RESV_DEPTH-1] = UNIT_INT;
        if (set_i) begin
            resv_d[set_slot_i] = 1'b1;
            src_d[set_slot_i]  = set_src_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resv_q <= '0;
            for (int i = 0; i < RESV_DEPTH; i++) begin
                src_q[i] <= UNIT_INT;
            end
        end else begin
            resv_q <= resv_d;
            for (int i = 0; i < RESV_DEPTH; i++) begin
                src_q[i] <= src_d[i];
            end
        end
    end

    assign resv_o = resv_q;
    assign src0_o = src_q[0];

endmodule

// File: rtl/issue_sched.sv
// ---------------------------------------------------------------------------
// issue_sched
// Single-port issue arbiter for four execution units sharing one common data
// bus. A unit may issue only if its result slot on the CDB is still free;
// priority is div > mul > {int, ls} with int/ls alternating round-robin.
//   clk, reset                     : clock, synchronous active-high reset
//   ready_int/ls/mul/div           : queue holds a ready entry
//   flush                          : mispredict flush, blocks all grants
//   issue_int/ls/mul/div           : one-hot (or zero) issue grant
//   div_busy                       : non-pipelined divider occupied
//   cdb_valid, cdb_src             : CDB owner for the current cycle
// ---------------------------------------------------------------------------
module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int LAT_INT = DEF_LAT_INT,
    parameter int LAT_LS  = DEF_LAT_LS,
    parameter int LAT_MUL = DEF_LAT_MUL,
    parameter int LAT_DIV = DEF_LAT_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready_int,
    input  logic       ready_ls,
    input  logic       ready_mul,
    input  logic       ready_div,
    input  logic       flush,
    output logic       issue_int,
    output logic       issue_ls,
    output logic       issue_mul,
    output logic       issue_div,
    output logic       div_busy,
    output logic       cdb_valid,
    output logic [1:0] cdb_src
);

    localparam logic [RESV_IDX_W-1:0] SLOT_INT = RESV_IDX_W'(LAT_INT - 1);
    localparam logic [RESV_IDX_W-1:0] SLOT_LS  = RESV_IDX_W'(LAT_LS - 1);
    localparam logic [RESV_IDX_W-1:0] SLOT_MUL = RESV_IDX_W'(LAT_MUL - 1);
    localparam logic [RESV_IDX_W-1:0] SLOT_DIV = RESV_IDX_W'(LAT_DIV - 1);
    localparam logic [RESV_IDX_W-1:0] DIV_LOAD = RESV_IDX_W'(LAT_DIV);

    logic [RESV_DEPTH-1:0] resv;
    unit_e                 src0;
    logic                  rr_q, rr_d;
    logic [RESV_IDX_W-1:0] divCnt_q, divCnt_d;
    logic                  eligInt, eligLs, eligMul, eligDiv;
    logic                  grantInt, grantLs, grantMul, grantDiv;
    logic                  setSlot;
    logic [RESV_IDX_W-1:0] setIdx;
    unit_e                 setSrc;

    assign div_busy = (divCnt_q != '0);

    assign eligInt = ready_int && !resv[LAT_INT];
    assign eligLs  = ready_ls  && !resv[LAT_LS];
    assign eligMul = ready_mul && !resv[LAT_MUL];
    assign eligDiv = ready_div && !resv[LAT_DIV] && !div_busy;

    // Fixed priority down to mul; a blocked higher unit falls through to the
    // next eligible one in the same cycle. rr_q=0 prefers int when both
    // int and ls are eligible.
    always_comb begin
        grantInt = 1'b0;
        grantLs  = 1'b0;
        grantMul = 1'b0;
        grantDiv = 1'b0;
        if (!reset && !flush) begin
            if (eligDiv) begin
                grantDiv = 1'b1;
            end else if (eligMul) begin
                grantMul = 1'b1;
            end else if (eligInt && (!eligLs || !rr_q)) begin
                grantInt = 1'b1;
            end else if (eligLs) begin
                grantLs = 1'b1;
            end
        end
    end

    assign issue_int = grantInt;
    assign issue_ls  = grantLs;
    assign issue_mul = grantMul;
    assign issue_div = grantDiv;

    // Translate the winning grant into the slot reservation it creates.
    always_comb begin
        setSlot = grantInt || grantLs || grantMul || grantDiv;
        setIdx  = SLOT_INT;
        setSrc  = UNIT_INT;
        if (grantDiv) begin
            setIdx = SLOT_DIV;
            setSrc = UNIT_DIV;
        end else if (grantMul) begin
            setIdx = SLOT_MUL;
            setSrc = UNIT_MUL;
        end else if (grantLs) begin
            setIdx = SLOT_LS;
            setSrc = UNIT_LS;
        end
    end

    // The pointer moves to the unit that did not just win; with no int/ls
    // grant (including during a flush) it stays where it is.
    always_comb begin
        rr_d = rr_q;
        if (grantInt) begin
            rr_d = 1'b1;
        end else if (grantLs) begin
            rr_d = 1'b0;
        end
    end

    // The divider counter keeps running through a flush so that an in-flight
    // divide still completes and frees the unit on schedule.
    always_comb begin
        divCnt_d = divCnt_q;
        if (grantDiv) begin
            divCnt_d = DIV_LOAD;
        end else if (divCnt_q != '0) begin
            divCnt_d = divCnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q     <= 1'b0;
            divCnt_q <= '0;
        end else begin
            rr_q     <= rr_d;
            divCnt_q <= divCnt_d;
        end
    end

    cdb_slot_tracker u_tracker (
        .clk        (clk),
        .reset      (reset),
        .set_i      (setSlot),
        .set_slot_i (setIdx),
        .set_src_i  (setSrc),
        .resv_o     (resv),
        .src0_o     (src0)
    );

    assign cdb_valid = resv[0];
    assign cdb_src   = resv[0] ? src0 : UNIT_INT;

endmodule

// File: tb/tb_issue_sched.sv
// ---------------------------------------------------------------------------
// tb_issue_sched
// Directed self-checking bench for issue_sched. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge. "Cycle n"
// is the n-th clock period after reset is released.
// ---------------------------------------------------------------------------
module tb_issue_sched;

    logic       clk;
    logic       reset;
    logic       ready_int, ready_ls, ready_mul, ready_div, flush;
    logic       issue_int, issue_ls, issue_mul, issue_div;
    logic       div_busy, cdb_valid;
    logic [1:0] cdb_src;
    logic [3:0] grants;

    int checks;
    int errors;

    issue_sched dut (
        .clk       (clk),
        .reset     (reset),
        .ready_int (ready_int),
        .ready_ls  (ready_ls),
        .ready_mul (ready_mul),
        .ready_div (ready_div),
        .flush     (flush),
        .issue_int (issue_int),
        .issue_ls  (issue_ls),
        .issue_mul (issue_mul),
        .issue_div (issue_div),
        .div_busy  (div_busy),
        .cdb_valid (cdb_valid),
        .cdb_src   (cdb_src)
    );

    assign grants = {issue_div, issue_mul, issue_ls, issue_int};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic setReady(input logic [3:0] r);
        {ready_div, ready_mul, ready_ls, ready_int} = r;
    endtask

    // Two reset cycles, then release; returns just after the edge starting cycle 0.
    task automatic doReset;
        reset = 1'b1;
        flush = 1'b0;
        setReady(4'b0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Grants are masked while reset is high; state is clear the cycle after.
    task automatic test_reset;
        reset = 1'b1;
        flush = 1'b0;
        setReady(4'b1111);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (grants !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_grants: got %b expected %b", grants, 4'b0000);
        end
        nextCycle();
        reset = 1'b0;
        setReady(4'b0000);
        @(negedge clk);
        checks++;
        if ({cdb_valid, div_busy, cdb_src} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_state: got valid/busy/src %b expected 0000",
                     {cdb_valid, div_busy, cdb_src});
        end
        nextCycle();
    endtask

    task automatic test_int_only;
        logic [3:0] expG;
        logic       expV;
        doReset();
        for (int c = 0; c < 5; c++) begin
            setReady((c < 3) ? 4'b0001 : 4'b0000);
            @(negedge clk);
            expG = (c < 3) ? 4'b0001 : 4'b0000;
            expV = (c >= 1 && c <= 3);
            checks++;
            if (grants !== expG) begin
                errors++;
                $display("[TB] FAIL int_only_grant c%0d: got %b expected %b", c, grants, expG);
            end
            checks++;
            if (cdb_valid !== expV || cdb_src !== 2'b00) begin
                errors++;
                $display("[TB] FAIL int_only_cdb c%0d: got v=%b src=%b expected v=%b src=00",
                         c, cdb_valid, cdb_src, expV);
            end
            nextCycle();
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] expG;
        logic [1:0] expS;
        doReset();
        for (int c = 0; c < 5; c++) begin
            setReady((c < 4) ? 4'b0011 : 4'b0000);
            @(negedge clk);
            if (c < 4) begin
                expG = (c % 2 == 0) ? 4'b0001 : 4'b0010;
                checks++;
                if (grants !== expG) begin
                    errors++;
                    $display("[TB] FAIL rr_grant c%0d: got %b expected %b", c, grants, expG);
                end
            end
            if (c >= 1) begin
                expS = ((c - 1) % 2 == 0) ? 2'b00 : 2'b01;
                checks++;
                if (cdb_valid !== 1'b1 || cdb_src !== expS) begin
                    errors++;
                    $display("[TB] FAIL rr_cdb c%0d: got v=%b src=%b expected v=1 src=%b",
                             c, cdb_valid, cdb_src, expS);
                end
            end
            nextCycle();
        end
    endtask

    task automatic test_mul_conflict;
        logic [3:0] rdy  [6] = '{4'b0100, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        logic [3:0] expG [6] = '{4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
        logic       expV [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] expS [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
        doReset();
        for (int c = 0; c < 6; c++) begin
            setReady(rdy[c]);
            @(negedge clk);
            checks++;
            if (grants !== expG[c]) begin
                errors++;
                $display("[TB] FAIL mul_conflict_grant c%0d: got %b expected %b", c, grants, expG[c]);
            end
            checks++;
            if (cdb_valid !== expV[c] || cdb_src !== expS[c]) begin
                errors++;
                $display("[TB] FAIL mul_conflict_cdb c%0d: got v=%b src=%b expected v=%b src=%b",
                         c, cdb_valid, cdb_src, expV[c], expS[c]);
            end
            nextCycle();
        end
        setReady(4'b0000);
    endtask

    task automatic test_div_busy;
        logic [3:0] expG;
        logic       expB;
        logic       expV;
        logic [1:0] expS;
        doReset();
        for (int c = 0; c < 9; c++) begin
            setReady(4'b1000);
            @(negedge clk);
            expG = (c == 0 || c == 8) ? 4'b1000 : 4'b0000;
            expB = (c >= 1 && c <= 7);
            expV = (c == 7);
            expS = (c == 7) ? 2'b11 : 2'b00;
            checks++;
            if (grants !== expG) begin
                errors++;
                $display("[TB] FAIL div_grant c%0d: got %b expected %b", c, grants, expG);
            end
            checks++;
            if (div_busy !== expB) begin
                errors++;
                $display("[TB] FAIL div_busy c%0d: got %b expected %b", c, div_busy, expB);
            end
            checks++;
            if (cdb_valid !== expV || cdb_src !== expS) begin
                errors++;
                $display("[TB] FAIL div_cdb c%0d: got v=%b src=%b expected v=%b src=%b",
                         c, cdb_valid, cdb_src, expV, expS);
            end
            nextCycle();
        end
        setReady(4'b0000);
    endtask

    // Div occupies slot 7 cycles out, which blocks mul at cycle 3 while
    // int still gets through.
    task automatic test_priority;
        logic [3:0] expG [5] = '{4'b1000, 4'b0100, 4'b0100, 4'b0001, 4'b0100};
        doReset();
        for (int c = 0; c < 5; c++) begin
            setReady(4'b1111);
            @(negedge clk);
            checks++;
            if (grants !== expG[c]) begin
                errors++;
                $display("[TB] FAIL priority_grant c%0d: got %b expected %b", c, grants, expG[c]);
            end
            nextCycle();
        end
        setReady(4'b0000);
    endtask

    task automatic test_flush;
        doReset();
        setReady(4'b0001);
        @(negedge clk);
        checks++;
        if (grants !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL flush_pre_grant: got %b expected 0001", grants);
        end
        nextCycle();
        setReady(4'b1111);
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (grants !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL flush_grant: got %b expected 0000", grants);
        end
        checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'b00) begin
            errors++;
            $display("[TB] FAIL flush_cdb: got v=%b src=%b expected v=1 src=00", cdb_valid, cdb_src);
        end
        nextCycle();
        flush = 1'b0;
        setReady(4'b0011);
        @(negedge clk);
        checks++;
        if (grants !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL flush_rr_hold: got %b expected 0010", grants);
        end
        nextCycle();
        setReady(4'b0000);
    endtask

    task automatic test_reset_mid;
        doReset();
        setReady(4'b0100);
        @(negedge clk);
        checks++;
        if (grants !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL midreset_mul: got %b expected 0100", grants);
        end
        nextCycle();
        setReady(4'b1000);
        @(negedge clk);
        checks++;
        if (grants !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL midreset_div: got %b expected 1000", grants);
        end
        nextCycle();
        setReady(4'b0001);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (grants !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midreset_grant: got %b expected 0000", grants);
        end
        nextCycle();
        reset = 1'b0;
        setReady(4'b0000);
        for (int c = 3; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (cdb_valid !== 1'b0 || div_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_state c%0d: got v=%b busy=%b expected v=0 busy=0",
                         c, cdb_valid, div_busy);
            end
            nextCycle();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        setReady(4'b0000);
        test_reset();
        test_int_only();
        test_round_robin();
        test_mul_conflict();
        test_div_busy();
        test_priority();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
